// File: rtl/sddr_line_adapter.sv
// rtl/sddr_line_adapter.sv - single-line write-back buffer between the CPU word bus and DDR line commands
// Merges byte-masked CPU writes into one 128-bit line; issues whole-line fill/evict commands downstream.
module sddr_line_adapter #(
    parameter int ADDRESS_BITS = 27,
    parameter int LINE_BITS    = 128
) (
    input  logic                    cpu_clock_i,
    input  logic                    reset_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDRESS_BITS-1:0] req_address_i,
    input  logic                    req_write_i,
    input  logic [31:0]             req_data_i,
    input  logic [3:0]              req_be_i,
    output logic                    rsp_valid_o,
    output logic [31:0]             rsp_data_o,
    input  logic                    flush_i,
    output logic                    flush_done_o,
    output logic                    data_cmd_valid_o,
    input  logic                    data_cmd_ack_i,
    output logic [ADDRESS_BITS-1:0] data_cmd_address_o,
    output logic                    data_cmd_write_o,
    output logic [LINE_BITS-1:0]    data_cmd_data_o,
    input  logic                    data_rsp_ready_i,
    input  logic [LINE_BITS-1:0]    data_rsp_data_i
);
    localparam int TAG_BITS = ADDRESS_BITS - 4;

    typedef enum logic [2:0] {
        S_IDLE, S_SERVE, S_EVICT_CMD, S_FILL_CMD, S_FILL_WAIT, S_FLUSH_CMD
    } state_t;

    state_t                  state_q, state_d;
    logic [LINE_BITS-1:0]    line_q;
    logic [TAG_BITS-1:0]     tag_q;
    logic                    line_valid_q, line_dirty_q;
    logic [ADDRESS_BITS-1:2] req_addr_q;
    logic                    req_write_q;
    logic [31:0]             req_data_q;
    logic [3:0]              req_be_q;
    logic                    flush_done_q;

    logic                    hit;
    logic [TAG_BITS-1:0]     req_tag;
    logic [6:0]              word_lsb;
    logic [31:0]             cur_word, merged_word;
    logic                    unused_addr_lsbs;

    assign unused_addr_lsbs = ^req_address_i[1:0];
    assign hit      = line_valid_q && (tag_q == req_address_i[ADDRESS_BITS-1:4]);
    assign req_tag  = req_addr_q[ADDRESS_BITS-1:4];
    assign word_lsb = {req_addr_q[3:2], 5'b0};
    assign cur_word = line_q[word_lsb +: 32];
    assign flush_done_o = flush_done_q;

    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (req_be_q[b]) merged_word[8*b +: 8] = req_data_q[8*b +: 8];
        end
    end

    // Command outputs decode the registered state, so valid never follows ack combinationally.
    always_comb begin
        state_d            = state_q;
        req_ready_o        = 1'b0;
        rsp_valid_o        = 1'b0;
        rsp_data_o         = 32'h0;
        data_cmd_valid_o   = 1'b0;
        data_cmd_write_o   = 1'b0;
        data_cmd_address_o = '0;
        data_cmd_data_o    = '0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = !flush_i;
                if (flush_i) begin
                    if (line_valid_q && line_dirty_q) state_d = S_FLUSH_CMD;
                end else if (req_valid_i) begin
                    if (hit)                                state_d = S_SERVE;
                    else if (line_valid_q && line_dirty_q)  state_d = S_EVICT_CMD;
                    else                                    state_d = S_FILL_CMD;
                end
            end
            S_SERVE: begin
                rsp_valid_o = 1'b1;
                rsp_data_o  = req_write_q ? 32'h0 : cur_word;
                state_d     = S_IDLE;
            end
            S_EVICT_CMD, S_FLUSH_CMD: begin
                data_cmd_valid_o   = 1'b1;
                data_cmd_write_o   = 1'b1;
                data_cmd_address_o = {tag_q, 4'h0};
                data_cmd_data_o    = line_q;
                if (data_cmd_ack_i) state_d = (state_q == S_EVICT_CMD) ? S_FILL_CMD : S_IDLE;
            end
            S_FILL_CMD: begin
                data_cmd_valid_o   = 1'b1;
                data_cmd_address_o = {req_tag, 4'h0};
                if (data_cmd_ack_i) state_d = S_FILL_WAIT;
            end
            S_FILL_WAIT: begin
                if (data_rsp_ready_i) state_d = S_SERVE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            line_q       <= '0;
            tag_q        <= '0;
            line_valid_q <= 1'b0;
            line_dirty_q <= 1'b0;
            req_addr_q   <= '0;
            req_write_q  <= 1'b0;
            req_data_q   <= '0;
            req_be_q     <= '0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (flush_i) begin
                        flush_done_q <= !(line_valid_q && line_dirty_q);
                    end else if (req_valid_i) begin
                        req_addr_q  <= req_address_i[ADDRESS_BITS-1:2];
                        req_write_q <= req_write_i;
                        req_data_q  <= req_data_i;
                        req_be_q    <= req_be_i;
                    end
                end
                S_SERVE: begin
                    if (req_write_q) begin
                        line_q[word_lsb +: 32] <= merged_word;
                        line_dirty_q           <= 1'b1;
                    end
                end
                S_EVICT_CMD: begin
                    if (data_cmd_ack_i) line_dirty_q <= 1'b0;
                end
                S_FLUSH_CMD: begin
                    if (data_cmd_ack_i) begin
                        line_dirty_q <= 1'b0;
                        flush_done_q <= 1'b1;
                    end
                end
                S_FILL_WAIT: begin
                    if (data_rsp_ready_i) begin
                        line_q       <= data_rsp_data_i;
                        tag_q        <= req_tag;
                        line_valid_q <= 1'b1;
                        line_dirty_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sddr_line_adapter.sv
// tb/tb_sddr_line_adapter.sv - directed vector bench for sddr_line_adapter
module tb_sddr_line_adapter;
    logic         clk = 1'b0;
    logic         reset_i;
    logic         req_valid, req_ready, req_write;
    logic [26:0]  req_address;
    logic [31:0]  req_data;
    logic [3:0]   req_be;
    logic         rsp_valid;
    logic [31:0]  rsp_data;
    logic         flush, flush_done;
    logic         cmd_valid, cmd_ack, cmd_write;
    logic [26:0]  cmd_address;
    logic [127:0] cmd_data;
    logic         drsp_ready;
    logic [127:0] drsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sddr_line_adapter dut (
        .cpu_clock_i(clk), .reset_i(reset_i),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_address_i(req_address),
        .req_write_i(req_write), .req_data_i(req_data), .req_be_i(req_be),
        .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
        .flush_i(flush), .flush_done_o(flush_done),
        .data_cmd_valid_o(cmd_valid), .data_cmd_ack_i(cmd_ack), .data_cmd_address_o(cmd_address),
        .data_cmd_write_o(cmd_write), .data_cmd_data_o(cmd_data),
        .data_rsp_ready_i(drsp_ready), .data_rsp_data_i(drsp_data)
    );

    typedef struct {
        logic [26:0] addr;
        logic        wr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    localparam logic [127:0] FILL0  = {32'h0F0E0D0C, 32'h0B0A0908, 32'hAABBCCDD, 32'hDDCCBBAA};
    localparam logic [127:0] MERGED = {32'h0F0EBEEF, 32'hA5A5A5A5, 32'hAA22CC44, 32'hDDCCBBAA};
    localparam logic [127:0] FILL2  = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    localparam logic [127:0] FLUSHED = {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'h00000000};
    localparam logic [127:0] FILL3  = {32'h77777777, 32'h66666666, 32'h55555555, 32'h44444444};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic do_req(input logic [26:0] a, input logic w, input logic [31:0] d, input logic [3:0] be);
        req_address = a; req_write = w; req_data = d; req_be = be; req_valid = 1'b1;
        #1 chk("req_ready", req_ready, 1);
        tick;
        req_valid = 1'b0;
    endtask

    task automatic hit(input vec_t v, input string name);
        do_req(v.addr, v.wr, v.data, v.be);
        chk({name, " rsp_valid"}, rsp_valid, 1);
        chk({name, " rsp_data"}, rsp_data, v.exp);
        chk({name, " no_cmd"}, cmd_valid, 0);
        tick;
    endtask

    task automatic expect_cmd(input logic wr, input logic [26:0] a, input logic [127:0] d,
                              input int hold, input string name);
        int n = 0;
        while (cmd_valid !== 1'b1 && n < 20) begin
            chk({name, " rsp_quiet"}, rsp_valid, 0);
            tick;
            n++;
        end
        chk({name, " valid"}, cmd_valid, 1);
        chk({name, " write"}, cmd_write, wr);
        chk({name, " address"}, cmd_address, a);
        if (wr) chk({name, " data"}, cmd_data, d);
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({name, " hold_valid"}, cmd_valid, 1);
            chk({name, " hold_payload"}, {cmd_write, cmd_address, wr ? cmd_data : 128'h0},
                {wr, a, wr ? d : 128'h0});
            chk({name, " hold_rsp"}, rsp_valid, 0);
        end
        cmd_ack = 1'b1;
        tick;
        cmd_ack = 1'b0;
    endtask

    task automatic give_fill(input logic [127:0] d, input logic [31:0] exp, input string name);
        drsp_ready = 1'b1; drsp_data = d;
        tick;
        drsp_ready = 1'b0;
        chk({name, " rsp_valid"}, rsp_valid, 1);
        chk({name, " rsp_data"}, rsp_data, exp);
        tick;
    endtask

    initial begin
        vecs[0] = '{27'h104, 1'b0, 32'h0,        4'h0,    32'hAABBCCDD};
        vecs[1] = '{27'h108, 1'b0, 32'h0,        4'h0,    32'h0B0A0908};
        vecs[2] = '{27'h10C, 1'b0, 32'h0,        4'h0,    32'h0F0E0D0C};
        vecs[3] = '{27'h104, 1'b1, 32'h11223344, 4'b0101, 32'h0};
        vecs[4] = '{27'h104, 1'b0, 32'h0,        4'h0,    32'hAA22CC44};
        vecs[5] = '{27'h108, 1'b1, 32'hA5A5A5A5, 4'b1111, 32'h0};
        vecs[6] = '{27'h108, 1'b0, 32'h0,        4'h0,    32'hA5A5A5A5};
        vecs[7] = '{27'h10C, 1'b1, 32'h0000BEEF, 4'b0011, 32'h0};
        vecs[8] = '{27'h10C, 1'b0, 32'h0,        4'h0,    32'h0F0EBEEF};
        vecs[9] = '{27'h103, 1'b0, 32'h0,        4'h0,    32'hDDCCBBAA};

        reset_i = 1'b1; req_valid = 0; req_address = 0; req_write = 0; req_data = 0; req_be = 0;
        flush = 0; cmd_ack = 0; drsp_ready = 0; drsp_data = 0;
        tick; tick;
        chk("reset req_ready", req_ready, 1);
        chk("reset outputs", {rsp_valid, rsp_data, flush_done, cmd_valid, cmd_write, cmd_address, cmd_data}, 0);
        reset_i = 1'b0;

        do_req(27'h100, 1'b0, 32'h0, 4'h0);
        expect_cmd(1'b0, 27'h100, 128'h0, 0, "first_fill");
        give_fill(FILL0, 32'hDDCCBBAA, "first_fill_rsp");

        for (int i = 0; i < 10; i++) hit(vecs[i], $sformatf("vec%0d", i));

        do_req(27'h2000, 1'b0, 32'h0, 4'h0);
        chk("dirty_miss no_rsp", rsp_valid, 0);
        expect_cmd(1'b1, 27'h100, MERGED, 5, "evict");
        expect_cmd(1'b0, 27'h2000, 128'h0, 0, "fill_after_evict");
        give_fill(FILL2, 32'h00000000, "fill2_rsp");

        hit('{27'h2004, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0}, "dirty_2004");
        flush = 1'b1;
        #1 chk("flush req_ready", req_ready, 0);
        tick;
        flush = 1'b0;
        expect_cmd(1'b1, 27'h2000, FLUSHED, 2, "flush_evict");
        chk("flush_done dirty", flush_done, 1);
        chk("flush_done excl", rsp_valid, 0);
        tick;
        chk("flush_done one_pulse", flush_done, 0);

        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush_done clean", flush_done, 1);
        chk("flush clean no_cmd", cmd_valid, 0);
        tick;

        flush = 1'b1; req_valid = 1'b1; req_address = 27'h2004; req_write = 1'b0;
        #1 chk("flush_wins ready", req_ready, 0);
        tick;
        flush = 1'b0;
        #1 chk("flush_wins done", flush_done, 1);
        chk("flush_wins ready_after", req_ready, 1);
        tick;
        req_valid = 1'b0;
        chk("flush_wins rsp_valid", rsp_valid, 1);
        chk("flush_wins rsp_data", rsp_data, 32'hCAFEF00D);
        tick;

        do_req(27'h3000, 1'b0, 32'h0, 4'h0);
        expect_cmd(1'b0, 27'h3000, 128'h0, 0, "prereset_fill");
        reset_i = 1'b1;
        tick;
        reset_i = 1'b0;
        drsp_ready = 1'b1; drsp_data = FILL3;
        tick;
        drsp_ready = 1'b0;
        chk("stray rsp_valid", rsp_valid, 0);
        chk("stray idle ready", req_ready, 1);
        chk("stray no_cmd", cmd_valid, 0);
        do_req(27'h3008, 1'b0, 32'h0, 4'h0);
        expect_cmd(1'b0, 27'h3000, 128'h0, 0, "refill");
        give_fill(FILL3, 32'h66666666, "refill_rsp");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
